addsub_lanes: RTL and testbench

Parametrised, pipelined, multi-lane signed add/subtract unit with per-lane accumulators, optional saturation and valid/ready flow control. It supersedes the single-lane, free-running add/sub register in front of the MMU_gen array. It feeds partial-sum correction and bias add/subtract into the matrix datapath, with backpressure from the consumer.

---
 rtl/addsub_pkg.sv | 27 ++
 rtl/addsub_lanes_if.sv | 29 ++
 rtl/addsub_lane.sv | 54 +++++
 rtl/addsub_lanes.sv | 70 +++++++
 tb/tb_addsub_lanes.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the multi-lane signed add/subtract unit.
package addsub_pkg;

    typedef enum logic [1:0] {
        ADD     = 2'b00,
        SUB     = 2'b01,
        ACC_ADD = 2'b10,
        ACC_SUB = 2'b11
    } op_e;

    // Widest lane the overflow helper supports; narrower sums are sign-extended up to it.
    localparam int MAX_W = 64;

    // Overflow of a w-bit signed result held in a (w+1)-bit sum: top two bits disagree.
    function automatic logic sum_ovf(input logic [MAX_W:0] sum, input int w);
        logic [6:0] hi;
        logic [6:0] lo;
        hi = 7'(w);
        lo = 7'(w - 1);
        return sum[hi] ^ sum[lo];
    endfunction

    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/addsub_lanes_if.sv
// Input and output channels of addsub_lanes. Both channels use valid/ready:
// a beat transfers on the rising edge where valid and ready are both high, and a
// sender holding valid keeps its payload stable until that edge.
interface addsub_lanes_if
    import addsub_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANES  = 4
);
    logic                    in_valid;
    logic                    in_ready;
    op_e                     op;
    logic [LANES*DATA_W-1:0] dataa;
    logic [LANES*DATA_W-1:0] datab;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] result;
    logic [LANES-1:0]        ovf;

    modport master (
        output in_valid, op, dataa, datab, out_ready,
        input  in_ready, out_valid, result, ovf
    );

    modport slave (
        input  in_valid, op, dataa, datab, out_ready,
        output in_ready, out_valid, result, ovf
    );
endinterface

// File: rtl/addsub_lane.sv
// One lane of the second stage: signed add/sub, overflow/saturation, result
// register and the lane accumulator.
module addsub_lane
    import addsub_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    input  logic              acc_clr,
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] res_c;
    logic [DATA_W:0]   sum;
    logic [MAX_W:0]    sum_ext;
    logic              ovf_c;
    logic              is_acc;

    always_comb begin
        is_acc  = op[1];
        operand = a;
        // A clear on the advance edge makes the accumulator operand read as zero.
        if (is_acc) operand = acc_clr ? '0 : acc;
        if (op[0]) sum = {operand[DATA_W-1], operand} - {b[DATA_W-1], b};
        else       sum = {operand[DATA_W-1], operand} + {b[DATA_W-1], b};
        sum_ext = {{(MAX_W-DATA_W){sum[DATA_W]}}, sum};
        ovf_c   = sum_ovf(sum_ext, DATA_W);
        res_c   = sum[DATA_W-1:0];
        if (ovf_c && SATURATE != 0) res_c = {sum[DATA_W], {(DATA_W-1){~sum[DATA_W]}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            if (adv) begin
                result <= res_c;
                ovf    <= ovf_c;
            end
            if (adv && is_acc) acc <= res_c;
            else if (acc_clr)  acc <= '0;
        end
    end
endmodule

// File: rtl/addsub_lanes.sv
// Two-stage multi-lane signed add/subtract unit: S1 holds the operands, S2
// (in the lanes) holds results; valid/ready flow control on both sides.
module addsub_lanes
    import addsub_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int LANES    = 4,
    parameter int SATURATE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           acc_clr,
    addsub_lanes_if.slave  io
);
    logic                    s1_valid;
    logic                    s2_valid;
    logic                    s1_load;
    logic                    s2_load;
    logic                    adv;
    op_e                     s1_op;
    logic [LANES*DATA_W-1:0] s1_a;
    logic [LANES*DATA_W-1:0] s1_b;
    logic [LANES*DATA_W-1:0] res_bus;
    logic [LANES-1:0]        ovf_bus;

    assign s2_load      = !s2_valid || io.out_ready;
    assign s1_load      = !s1_valid || s2_load;
    assign adv          = s1_valid && s2_load;
    assign io.in_ready  = s1_load;
    assign io.out_valid = s2_valid;
    assign io.result    = res_bus;
    assign io.ovf       = ovf_bus;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_op    <= ADD;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= io.in_valid;
                if (io.in_valid) begin
                    s1_op <= io.op;
                    s1_a  <= io.dataa;
                    s1_b  <= io.datab;
                end
            end
            if (s2_load) s2_valid <= s1_valid;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        addsub_lane #(
            .DATA_W   (DATA_W),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv     (adv),
            .acc_clr (acc_clr),
            .op      (s1_op),
            .a       (s1_a[lane_lsb(i, DATA_W) +: DATA_W]),
            .b       (s1_b[lane_lsb(i, DATA_W) +: DATA_W]),
            .result  (res_bus[lane_lsb(i, DATA_W) +: DATA_W]),
            .ovf     (ovf_bus[i])
        );
    end
endmodule

// File: tb/tb_addsub_lanes.sv
// Bench for addsub_lanes: a saturating and a wrapping instance share one stimulus
// stream; results are checked against an integer model of the lane arithmetic.
module tb_addsub_lanes;
  import addsub_pkg::*;

  localparam int W = 8;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic acc_clr = 1'b0;

  always #5 clk = ~clk;

  addsub_lanes_if #(.DATA_W(W), .LANES(L)) io1();
  addsub_lanes_if #(.DATA_W(W), .LANES(L)) io0();

  assign io0.in_valid  = io1.in_valid;
  assign io0.op        = io1.op;
  assign io0.dataa     = io1.dataa;
  assign io0.datab     = io1.datab;
  assign io0.out_ready = io1.out_ready;

  addsub_lanes #(.DATA_W(W), .LANES(L), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .acc_clr(acc_clr), .io(io1)
  );
  addsub_lanes #(.DATA_W(W), .LANES(L), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .acc_clr(acc_clr), .io(io0)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [35:0] exp_q[$];   // {ovf_wrap, ovf_sat, res_wrap, res_sat}
  int out_cyc[$];
  int acc_m[2][2];         // [1]=saturating instance, [0]=wrapping instance
  logic prev_stall = 1'b0;
  logic [17:0] prev_val;
  bit done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] pk(input int l0, input int l1);
    return {l1[7:0], l0[7:0]};
  endfunction

  task automatic clear_model();
    for (int m = 0; m < 2; m++)
      for (int l = 0; l < 2; l++) acc_m[m][l] = 0;
  endtask

  // Transaction-level reference: accumulators update in acceptance order.
  task automatic model(input op_e op, input logic [15:0] a, input logic [15:0] b, input bit clr);
    logic [35:0] e;
    logic [1:0] ob;
    e = '0;
    ob = op;
    for (int m = 0; m < 2; m++) begin
      for (int l = 0; l < 2; l++) begin
        int x, y, r, v;
        logic [7:0] a8, b8;
        bit o;
        a8 = a[l*8 +: 8];
        b8 = b[l*8 +: 8];
        if (clr) acc_m[m][l] = 0;
        x = ob[1] ? acc_m[m][l] : int'($signed(a8));
        y = int'($signed(b8));
        r = ob[0] ? x - y : x + y;
        o = (r > 127) || (r < -128);
        if (r > 127) v = (m == 1) ? 127 : r - 256;
        else if (r < -128) v = (m == 1) ? -128 : r + 256;
        else v = r;
        if (ob[1]) acc_m[m][l] = v;
        if (m == 1) begin
          e[l*8 +: 8] = v[7:0];
          e[32 + l] = o;
        end else begin
          e[16 + l*8 +: 8] = v[7:0];
          e[34 + l] = o;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input op_e op, input logic [15:0] a, input logic [15:0] b, input bit clr);
    bit ok;
    ok = 0;
    io1.in_valid = 1'b1;
    io1.op = op;
    io1.dataa = a;
    io1.datab = b;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (io1.in_ready) begin
        model(op, a, b, clr);
        ok = 1;
      end
      @(posedge clk); #1;
    end
    io1.in_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'(ok), 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("drained_idle", io1.out_valid, 0);
  endtask

  // Output monitor: mid-cycle sampling, in-order scoreboard and hold-while-stalled check.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("hold_valid", io1.out_valid, 1);
        chk("hold_data", {io1.ovf, io1.result}, prev_val);
      end
      if (io1.out_valid && io1.out_ready) begin
        chk("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          logic [35:0] e;
          e = exp_q.pop_front();
          chk("res_sat", io1.result, e[15:0]);
          chk("res_wrap", io0.result, e[31:16]);
          chk("ovf_sat", io1.ovf, e[33:32]);
          chk("ovf_wrap", io0.ovf, e[35:34]);
          out_cyc.push_back(cyc);
        end
      end
      prev_stall = io1.out_valid && !io1.out_ready;
      prev_val = {io1.ovf, io1.result};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int k;
    int n0;
    io1.in_valid = 1'b0;
    io1.op = ADD;
    io1.dataa = '0;
    io1.datab = '0;
    io1.out_ready = 1'b1;
    clear_model();

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", io1.in_ready, 1);
    chk("rst_out_valid", io1.out_valid, 0);
    chk("rst_result", io1.result, 0);
    chk("rst_ovf", io1.ovf, 0);
    chk("rst_result_wrap", io0.result, 0);
    @(posedge clk); #1;

    // ADD, latency, positive overflow, SUB with negative overflow
    send(ADD, pk(100, -5), pk(27, 28), 0);
    chk("lat_after_accept", io1.out_valid, 0);
    @(posedge clk); #1;
    chk("lat_two_edges", io1.out_valid, 1);
    chk("add_direct", io1.result, pk(127, 23));
    send(ADD, pk(100, 0), pk(28, 0), 0);
    send(SUB, pk(-128, 10), pk(1, -20), 0);
    drain();

    // Clear, then a bubble-free ACC_ADD chain into saturation
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    clear_model();
    n0 = out_cyc.size();
    repeat (3) send(ACC_ADD, pk(11, 22), pk(50, -50), 0);
    drain();
    chk("no_bubble_1", out_cyc[n0 + 1] - out_cyc[n0], 1);
    chk("no_bubble_2", out_cyc[n0 + 2] - out_cyc[n0 + 1], 1);

    // Clear coinciding with the ACC advance edge
    send(ACC_ADD, pk(99, 99), pk(7, 7), 1);
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    send(ACC_ADD, pk(0, 0), pk(0, 0), 0);
    drain();

    // Backpressure: only two held, then in-order release
    io1.out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      if (k < 4) begin
        io1.in_valid = 1'b1;
        io1.op = ADD;
        io1.dataa = '0;
        io1.datab = pk(k + 1, k + 1);
      end
      @(negedge clk);
      if (k >= 2) chk("stall_in_ready_low", io1.in_ready, 0);
      if (io1.in_ready && k < 4) begin
        model(ADD, '0, pk(k + 1, k + 1), 0);
        k++;
      end
      @(posedge clk); #1;
    end
    io1.in_valid = 1'b0;
    chk("stall_accepted", k, 2);
    io1.out_ready = 1'b1;
    for (int j = k; j < 4; j++) send(ADD, '0, pk(j + 1, j + 1), 0);
    drain();

    // Reset with two transactions in flight
    io1.out_ready = 1'b0;
    send(ADD, pk(1, 1), pk(1, 1), 0);
    send(ADD, pk(2, 2), pk(2, 2), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", io1.out_valid, 0);
    chk("midrst_in_ready", io1.in_ready, 1);
    chk("midrst_result", io1.result, 0);
    exp_q.delete();
    clear_model();
    @(posedge clk); #1;
    rst_n = 1'b1;
    io1.out_ready = 1'b1;
    send(ADD, pk(3, 3), pk(4, 4), 0);
    chk("post_rst_lat1", io1.out_valid, 0);
    @(posedge clk); #1;
    chk("post_rst_lat2", io1.out_valid, 1);
    chk("post_rst_sum", io1.result, pk(7, 7));
    send(ACC_ADD, pk(5, 5), pk(0, 0), 0);
    drain();

    // Random traffic with random backpressure
    done = 0;
    fork
      begin
        for (int i = 0; i < 60; i++)
          send(op_e'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 0);
        done = 1;
      end
      begin
        while (!done) begin
          io1.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    io1.out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
